// File: rtl/snake_pixel_responder_if.sv
// Bundles the pixel-query and game-control signals between the game controller
// (master) and the snake state/pixel responder (slave).
interface snake_pixel_responder_if;
   logic [9:0] x_pos;
   logic [9:0] y_pos;
   logic [1:0] game_status;
   logic       move_tick;
   logic [1:0] dir;
   logic       grow;
   logic [1:0] snake;
   logic [5:0] head_x;
   logic [4:0] head_y;
   logic [5:0] length;
   logic       hit_wall;
   logic       hit_self;

   modport master (
      output x_pos, y_pos, game_status, move_tick, dir, grow,
      input  snake, head_x, head_y, length, hit_wall, hit_self
   );

   modport slave (
      input  x_pos, y_pos, game_status, move_tick, dir, grow,
      output snake, head_x, head_y, length, hit_wall, hit_self
   );
endinterface

// File: rtl/snake_pixel_responder.sv
// Snake body state machine on a 40x30 cell grid plus a registered per-pixel
// classifier (none / head / body / wall) for the video scan-out.
module snake_pixel_responder #(
   parameter int MAX_LEN    = 16,
   parameter int CELL_SHIFT = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   snake_pixel_responder_if.slave  bus
);

   logic [5:0] seg_x_q [MAX_LEN];
   logic [4:0] seg_y_q [MAX_LEN];
   logic [5:0] len_q;
   logic [1:0] cur_dir_q;
   logic       grow_pend_q;
   logic       hit_wall_q;
   logic       hit_self_q;
   logic [1:0] snake_q;

   logic [1:0] dir_d;
   logic [5:0] hx_d;
   logic [4:0] hy_d;
   logic [5:0] len_d;
   logic       wall_d;
   logic       self_d;
   logic [1:0] pix_d;
   logic       active;
   logic       accept;
   logic       growing;
   logic       can_grow;
   logic [5:0] cell_x;
   logic [5:0] cell_y;
   logic       in_range;

   function automatic logic [5:0] init_x(input int i);
      case (i)
         0:       init_x = 6'd20;
         1:       init_x = 6'd19;
         2:       init_x = 6'd18;
         default: init_x = 6'd0;
      endcase
   endfunction

   function automatic logic [4:0] init_y(input int i);
      init_y = (i < 3) ? 5'd15 : 5'd0;
   endfunction

   assign active   = (bus.game_status == 2'b01) && !hit_wall_q && !hit_self_q;
   assign accept   = active && bus.move_tick;
   assign growing  = grow_pend_q || bus.grow;
   assign can_grow = growing && (len_q < 6'(MAX_LEN));
   assign len_d    = can_grow ? len_q + 6'd1 : len_q;

   // Reversal onto the neck is ignored: up/down and left/right differ only in bit 0.
   always_comb begin
      dir_d = cur_dir_q;
      if (bus.dir != (cur_dir_q ^ 2'b01)) dir_d = bus.dir;
      hx_d = seg_x_q[0];
      hy_d = seg_y_q[0];
      case (dir_d)
         2'b00:   hy_d = seg_y_q[0] - 5'd1;
         2'b01:   hy_d = seg_y_q[0] + 5'd1;
         2'b10:   hx_d = seg_x_q[0] - 6'd1;
         default: hx_d = seg_x_q[0] + 6'd1;
      endcase
   end

   assign wall_d = (hx_d == 6'd0) || (hx_d == 6'd39) || (hy_d == 5'd0) || (hy_d == 5'd29);

   // The tail cell is free unless the snake is lengthening this step.
   always_comb begin
      self_d = 1'b0;
      for (int i = 1; i < MAX_LEN; i++) begin
         if ((seg_x_q[i] == hx_d) && (seg_y_q[i] == hy_d)) begin
            if ((6'(i) + 6'd2 <= len_q) || ((6'(i) + 6'd1 == len_q) && can_grow))
               self_d = 1'b1;
         end
      end
   end

   assign cell_x   = 6'(bus.x_pos >> CELL_SHIFT);
   assign cell_y   = 6'(bus.y_pos >> CELL_SHIFT);
   assign in_range = (bus.x_pos < 10'd640) && (bus.y_pos < 10'd480);

   always_comb begin
      pix_d = 2'b00;
      if (in_range) begin
         if ((cell_x == 6'd0) || (cell_x == 6'd39) || (cell_y == 6'd0) || (cell_y == 6'd29)) begin
            pix_d = 2'b11;
         end else if ((cell_x == seg_x_q[0]) && (cell_y == {1'b0, seg_y_q[0]})) begin
            pix_d = 2'b01;
         end else begin
            for (int i = 1; i < MAX_LEN; i++) begin
               if ((6'(i) < len_q) && (cell_x == seg_x_q[i]) && (cell_y == {1'b0, seg_y_q[i]}))
                  pix_d = 2'b10;
            end
         end
      end
   end

   // Restart status behaves exactly like reset, every cycle it is held.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < MAX_LEN; i++) begin
            seg_x_q[i] <= init_x(i);
            seg_y_q[i] <= init_y(i);
         end
         len_q       <= 6'd3;
         cur_dir_q   <= 2'b11;
         grow_pend_q <= 1'b0;
         hit_wall_q  <= 1'b0;
         hit_self_q  <= 1'b0;
         snake_q     <= 2'b00;
      end else if (bus.game_status == 2'b11) begin
         for (int i = 0; i < MAX_LEN; i++) begin
            seg_x_q[i] <= init_x(i);
            seg_y_q[i] <= init_y(i);
         end
         len_q       <= 6'd3;
         cur_dir_q   <= 2'b11;
         grow_pend_q <= 1'b0;
         hit_wall_q  <= 1'b0;
         hit_self_q  <= 1'b0;
         snake_q     <= 2'b00;
      end else begin
         snake_q <= pix_d;
         if (accept) begin
            cur_dir_q <= dir_d;
            if (wall_d) begin
               hit_wall_q  <= 1'b1;
               grow_pend_q <= growing;
            end else if (self_d) begin
               hit_self_q  <= 1'b1;
               grow_pend_q <= growing;
            end else begin
               for (int i = 1; i < MAX_LEN; i++) begin
                  seg_x_q[i] <= seg_x_q[i-1];
                  seg_y_q[i] <= seg_y_q[i-1];
               end
               seg_x_q[0]  <= hx_d;
               seg_y_q[0]  <= hy_d;
               len_q       <= len_d;
               grow_pend_q <= 1'b0;
            end
         end else if (active && bus.grow) begin
            grow_pend_q <= 1'b1;
         end
      end
   end

   assign bus.snake    = snake_q;
   assign bus.head_x   = seg_x_q[0];
   assign bus.head_y   = seg_y_q[0];
   assign bus.length   = len_q;
   assign bus.hit_wall = hit_wall_q;
   assign bus.hit_self = hit_self_q;

endmodule

// File: tb/tb_snake_pixel_responder.sv
// Directed bench for snake_pixel_responder: movement, growth, collisions,
// restart and pixel classification against hand-computed expectations.
module tb_snake_pixel_responder;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   snake_pixel_responder_if bus();

   snake_pixel_responder #(.MAX_LEN(16), .CELL_SHIFT(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic step(input logic [1:0] d, input logic g);
      bus.dir       = d;
      bus.grow      = g;
      bus.move_tick = 1'b1;
      cyc();
      bus.move_tick = 1'b0;
      bus.grow      = 1'b0;
   endtask

   task automatic restart();
      bus.game_status = 2'b11;
      cyc();
      bus.game_status = 2'b01;
   endtask

   task automatic query(input string tag, input int x, input int y, input int exp);
      bus.x_pos = 10'(x);
      bus.y_pos = 10'(y);
      cyc();
      chk(tag, 32'(bus.snake), 32'(exp));
   endtask

   task automatic chk_head(input string tag, input int x, input int y);
      chk({tag, "_x"}, 32'(bus.head_x), 32'(x));
      chk({tag, "_y"}, 32'(bus.head_y), 32'(y));
   endtask

   initial begin
      bus.x_pos       = '0;
      bus.y_pos       = '0;
      bus.game_status = 2'b00;
      bus.move_tick   = 1'b0;
      bus.dir         = 2'b00;
      bus.grow        = 1'b0;

      repeat (3) cyc();
      chk_head("rst_head", 20, 15);
      chk("rst_len", 32'(bus.length), 32'd3);
      chk("rst_hitw", 32'(bus.hit_wall), 32'd0);
      chk("rst_hits", 32'(bus.hit_self), 32'd0);
      chk("rst_snake", 32'(bus.snake), 32'd0);

      rst = 1'b1;
      bus.game_status = 2'b01;
      cyc();

      step(2'b11, 1'b0);
      chk_head("step_r", 21, 15);
      chk("step_r_len", 32'(bus.length), 32'd3);
      query("pix_head", 336, 240, 1);
      query("pix_body", 320, 240, 2);
      query("pix_wall", 0, 0, 3);
      query("pix_none", 160, 160, 0);

      step(2'b10, 1'b0);
      chk_head("reverse_ign", 22, 15);

      query("pix_x700", 700, 0, 0);
      query("pix_y500", 0, 500, 0);

      bus.game_status = 2'b00;
      step(2'b11, 1'b0);
      chk_head("idle_tick", 22, 15);
      bus.game_status = 2'b01;

      restart();
      chk_head("restart", 20, 15);
      bus.grow = 1'b1;
      cyc();
      bus.grow = 1'b0;
      cyc();
      chk("pend_nolen", 32'(bus.length), 32'd3);
      step(2'b11, 1'b0);
      chk("pend_len", 32'(bus.length), 32'd4);

      restart();
      step(2'b11, 1'b1);
      chk("grow_len", 32'(bus.length), 32'd4);
      chk_head("grow_head", 21, 15);
      query("tail_kept", 288, 240, 2);
      query("beyond_tail", 272, 240, 0);
      for (int k = 0; k < 13; k++) step(2'b11, 1'b1);
      chk("len_cap", 32'(bus.length), 32'd16);
      chk_head("cap_head", 34, 15);

      for (int k = 0; k < 4; k++) step(2'b11, 1'b0);
      chk_head("at_38", 38, 15);
      chk("pre_wall", 32'(bus.hit_wall), 32'd0);
      step(2'b11, 1'b0);
      chk("hit_wall", 32'(bus.hit_wall), 32'd1);
      chk_head("wall_stay", 38, 15);
      step(2'b00, 1'b0);
      chk_head("wall_ignored", 38, 15);
      restart();
      chk("wall_clr", 32'(bus.hit_wall), 32'd0);
      chk_head("wall_rst", 20, 15);
      chk("wall_rst_len", 32'(bus.length), 32'd3);

      step(2'b11, 1'b1);
      step(2'b11, 1'b1);
      chk("len5", 32'(bus.length), 32'd5);
      step(2'b00, 1'b0);
      step(2'b10, 1'b0);
      chk_head("loop_pre", 21, 14);
      step(2'b01, 1'b0);
      chk("hit_self", 32'(bus.hit_self), 32'd1);
      chk_head("self_stay", 21, 14);

      restart();
      chk("self_clr", 32'(bus.hit_self), 32'd0);
      step(2'b11, 1'b1);
      step(2'b00, 1'b0);
      step(2'b10, 1'b0);
      step(2'b01, 1'b0);
      chk("tail_legal", 32'(bus.hit_self), 32'd0);
      chk_head("tail_move", 20, 15);

      restart();
      step(2'b11, 1'b0);
      bus.dir       = 2'b11;
      bus.move_tick = 1'b1;
      rst           = 1'b0;
      cyc();
      chk_head("rst_mid", 20, 15);
      bus.move_tick = 1'b0;
      rst = 1'b1;
      cyc();
      chk("rst_mid_len", 32'(bus.length), 32'd3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
